float_to_fixed_pipe: RTL and testbench
======================================

Name: float_to_fixed_pipe

Overview:
Pipelined, parametrised IEEE-754 single-precision to signed fixed-point converter with valid/ready handshakes on both sides. The binary point position and the rounding mode are selected per transaction. The output is saturated two's complement with status flags. It replaces the single-cycle combinational converter in the datapath and streams one conversion per cycle under backpressure.

Parameters:
OUT_W, 32, width of the fixed-point result, range 8..64
POS_W, $clog2(OUT_W), width of the fixpointpos field (localparam, derived)

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  converter can accept an input this cycle
float  in  32  IEEE-754 single-precision operand
fixpointpos  in  POS_W  number of fractional bits in the result, 0..OUT_W-1
round_mode  in  2  0 trunc (toward zero), 1 nearest-even, 2 floor, 3 ceil
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
result  out  OUT_W  signed two's-complement fixed-point value
flags  out  3  [0] inexact, [1] overflow/saturated, [2] invalid (NaN)

Behaviour:
- Reset: synchronous, active-high, on clk. Clears all stage valids. out_valid=0, result=0, flags=0, in_ready=1 the cycle after rst deasserts. A reset mid-stream discards all in-flight transactions. No partial output appears.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - 3-stage pipeline, S1 unpack, S2 align, S3 round/negate/saturate. Latency is exactly 3 cycles with out_ready held high. Throughput is 1 per cycle.
- Stall rule: a stage advances when it is empty or the next stage advances. in_ready = !S1.valid || S1 advances, so bubbles are absorbed.
  - While out_valid=1 && out_ready=0, result and flags hold stable.
  - With 3 entries held, in_ready=0.
  - Order is preserved. No drop, no duplicate.
- S1:
  - s = float[31], e = float[30:23], m = {1, float[22:0]}.
  - Classify: zero (e=0, m=0), denorm (e=0, m!=0), inf (e=255, m=0), NaN (e=255, m!=0).
  - k = e - 127 + fixpointpos - 23, signed 10-bit.
- S2:
  - If k>=0, mag = m << k, with ovf if the bit index of the leading one, 23+k, is >= OUT_W.
  - If k<0, mag = m >> -k, and guard bit, round bit and sticky are captured. A shift of 25 or more gives mag=0 with all discarded bits in sticky.
- S3:
  - Apply round_mode to the magnitude using sign, LSB, round bit and sticky:
    - trunc: no increment.
    - RNE: increment when r && (sticky || lsb).
    - floor: increment when s && (r || sticky).
    - ceil: increment when !s && (r || sticky).
  - Negate if s.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. -2^(OUT_W-1) is exact, with no overflow.
  - inexact = r || sticky, except when saturated.
- Special operands:
  - +/-0 gives 0 with flags 0.
  - Denorm is flushed: result 0, inexact=1, except floor of a negative denorm gives -1 and ceil of a positive denorm gives +1, with inexact=1.
  - +inf gives max positive and -inf gives min negative, with overflow=1.
  - NaN gives 0 with invalid=1 and other flags 0.
- fixpointpos values >= OUT_W (only possible when OUT_W is not a power of 2) are clamped to OUT_W-1.

Decomposition:
- Package float_fixed_pkg:
  - FP32 field widths and bias 127.
  - round_mode_t enum (RM_TRUNC, RM_RNE, RM_FLOOR, RM_CEIL).
  - Flag bit indices FLG_INEXACT, FLG_OVF, FLG_INVALID.
  - fp_class_t enum (ZERO, DENORM, NORM, INF, NAN).
- One sub-module: fix_round_sat, the combinational S3 logic (round increment, conditional negate, saturate). It is parametrised by OUT_W and unit-testable on its own.

Test Plan:
- 0x3FC00000 (1.5), pos 4, trunc, out_ready=1 -> result 0x00000018, flags 0, out_valid exactly 3 cycles after acceptance.
- 0xC0300000 (-2.75), pos 2, trunc -> 0xFFFFFFF5 (-11), flags 0. 0x40200000 (2.5), pos 0, all four modes:
  - trunc 2, RNE 2, floor 2, ceil 3, inexact=1 in all four.
  - 0xC0200000 (-2.5) with floor -> 0xFFFFFFFD.
- 0x501502F9 (1e10), pos 0 -> 0x7FFFFFFF, overflow=1. 0xCF000000 (-2^31), pos 0 -> 0x80000000, flags 0. 0xFF800000 (-inf) -> 0x80000000, overflow=1. 0x7FC00000 (NaN) -> 0, invalid=1.
- Backpressure: present 6 back-to-back inputs with out_ready=0 for 5 cycles. Required:
  - in_ready falls after 3 accepts.
  - result is held stable while stalled.
  - After release, all 6 results appear in order, one per cycle.
- Reset mid-stream: assert rst for 1 cycle with 2 transactions in flight -> out_valid=0 the next cycle, none of the in-flight results ever appear, and a new input afterwards completes with 3-cycle latency.

Source files
------------

// File: rtl/float_fixed_pkg.sv
// Shared types and constants for the float-to-fixed converter.
package float_fixed_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam int FLG_INEXACT = 0;
  localparam int FLG_OVF     = 1;
  localparam int FLG_INVALID = 2;

  typedef enum logic [1:0] {
    RM_TRUNC = 2'd0,
    RM_RNE   = 2'd1,
    RM_FLOOR = 2'd2,
    RM_CEIL  = 2'd3
  } round_mode_t;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORM,
    INF,
    NAN
  } fp_class_t;

  function automatic fp_class_t classify(input logic [FP_EXP_W-1:0] e,
                                         input logic [FP_MAN_W-1:0] frac);
    if (e == '0)
      return (frac == '0) ? ZERO : DENORM;
    else if (e == '1)
      return (frac == '0) ? INF : NAN;
    else
      return NORM;
  endfunction

endpackage

// File: rtl/fix_round_sat.sv
// Combinational rounding increment, conditional negate and saturation.
module fix_round_sat
  import float_fixed_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             sign,
  input  logic [OUT_W-1:0] mag,
  input  logic             rbit,
  input  logic             sticky,
  input  logic             ovf,
  input  round_mode_t      mode,
  output logic [OUT_W-1:0] result,
  output logic             inexact,
  output logic             overflow
);

  logic             inc;
  logic [OUT_W:0]   mag_r;
  logic [OUT_W-1:0] mag_n;
  logic             sat;

  always_comb begin
    inc = 1'b0;
    unique case (mode)
      RM_TRUNC: inc = 1'b0;
      RM_RNE:   inc = rbit && (sticky || mag[0]);
      RM_FLOOR: inc = sign && (rbit || sticky);
      RM_CEIL:  inc = !sign && (rbit || sticky);
      default:  inc = 1'b0;
    endcase
  end

  assign mag_r = {1'b0, mag} + {{OUT_W{1'b0}}, inc};
  assign mag_n = mag_r[OUT_W-1:0];

  // Negative side may reach exactly 2^(OUT_W-1) without saturating.
  always_comb begin
    sat = ovf || mag_r[OUT_W];
    if (!sign)
      sat = sat || mag_r[OUT_W-1];
    else
      sat = sat || (mag_r[OUT_W-1] && (mag_r[OUT_W-2:0] != '0));
  end

  always_comb begin
    result = '0;
    if (sat)
      result = sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else if (sign)
      result = -mag_n;
    else
      result = mag_n;
  end

  assign inexact  = (rbit || sticky) && !sat;
  assign overflow = sat;

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage FP32 to saturated signed fixed-point converter with valid/ready.
module float_to_fixed_pipe
  import float_fixed_pkg::*;
#(
  parameter  int OUT_W = 32,
  localparam int POS_W = $clog2(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float,
  input  logic [POS_W-1:0] fixpointpos,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic [2:0]       flags
);

  localparam int WW = OUT_W + 24;

  logic adv1, adv2, adv3;
  logic v1, v2;

  logic               s1_sign;
  fp_class_t          s1_class;
  logic [23:0]        s1_m;
  logic signed [9:0]  s1_k;
  round_mode_t        s1_mode;

  logic               s2_sign;
  logic               s2_nan;
  logic [OUT_W-1:0]   s2_mag;
  logic               s2_r;
  logic               s2_st;
  logic               s2_ovf;
  round_mode_t        s2_mode;

  logic [POS_W-1:0]   pos_c;
  logic [9:0]         k_n;

  logic [OUT_W-1:0]   mag_n;
  logic               r_n, st_n, ovf_n;
  logic signed [10:0] lead;
  logic [9:0]         sh;
  logic [47:0]        rwide;

  logic [OUT_W-1:0]   rs_result;
  logic               rs_inexact, rs_ovf;

  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // S1: clamp the binary point and form the alignment shift k.
  always_comb begin
    pos_c = fixpointpos;
    if (int'(fixpointpos) >= OUT_W)
      pos_c = POS_W'(OUT_W - 1);
    k_n = 10'(float[30:23]) + 10'(pos_c) - 10'(FP_BIAS + FP_MAN_W);
  end

  // S2: align; denormals are flushed by presenting a pure sticky residue.
  always_comb begin
    mag_n = '0;
    r_n   = 1'b0;
    st_n  = 1'b0;
    ovf_n = 1'b0;
    lead  = $signed({s1_k[9], s1_k}) + 11'sd23;
    sh    = 10'(-s1_k);
    rwide = {s1_m, 24'b0} >> sh;
    unique case (s1_class)
      ZERO:   ;
      DENORM: st_n  = 1'b1;
      INF:    ovf_n = 1'b1;
      NAN:    ;
      NORM: begin
        ovf_n = (lead >= $signed(11'(OUT_W)));
        if (!s1_k[9]) begin
          mag_n = OUT_W'(WW'(s1_m) << s1_k[7:0]);
        end else if (sh >= 10'd25) begin
          st_n = 1'b1;
        end else begin
          mag_n = OUT_W'(rwide[47:24]);
          r_n   = rwide[23];
          st_n  = rwide[22:0] != '0;
        end
      end
      default: ;
    endcase
  end

  fix_round_sat #(.OUT_W(OUT_W)) u_round_sat (
    .sign     (s2_sign),
    .mag      (s2_mag),
    .rbit     (s2_r),
    .sticky   (s2_st),
    .ovf      (s2_ovf),
    .mode     (s2_mode),
    .result   (rs_result),
    .inexact  (rs_inexact),
    .overflow (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sign  <= float[31];
          s1_class <= classify(float[30:23], float[22:0]);
          s1_m     <= {1'b1, float[22:0]};
          s1_k     <= k_n;
          s1_mode  <= round_mode_t'(round_mode);
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign <= s1_sign;
          s2_nan  <= (s1_class == NAN);
          s2_mag  <= mag_n;
          s2_r    <= r_n;
          s2_st   <= st_n;
          s2_ovf  <= ovf_n;
          s2_mode <= s1_mode;
        end
      end
      if (adv3) begin
        out_valid <= v2;
        if (v2) begin
          if (s2_nan) begin
            result <= '0;
            flags  <= 3'b000;
            flags[FLG_INVALID] <= 1'b1;
          end else begin
            result <= rs_result;
            flags  <= 3'b000;
            flags[FLG_INEXACT] <= rs_inexact;
            flags[FLG_OVF]     <= rs_ovf;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed self-checking bench for float_to_fixed_pipe.
module tb_float_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_in;
  logic [4:0]  pos;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  float_to_fixed_pipe #(.OUT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .float       (float_in),
    .fixpointpos (pos),
    .round_mode  (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] f, input int p,
                         input logic [1:0] rm, input logic [31:0] er, input logic [2:0] ef);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    float_in = f;
    pos      = 5'(p);
    mode     = rm;
    cyc = 0;
    while (!in_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 10);
    check({tag, " latency"}, 64'(cyc), 64'd3);
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " flags"}, 64'(flags), 64'(ef));
  endtask

  logic [31:0] bp_vec [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

  initial begin
    int sent, got, first_out, last_out;
    rst       = 1'b1;
    in_valid  = 1'b0;
    float_in  = '0;
    pos       = '0;
    mode      = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);

    run_one("1.5 p4 trunc",   32'h3FC00000, 4,  2'd0, 32'h00000018, 3'b000);
    run_one("-2.75 p2 trunc", 32'hC0300000, 2,  2'd0, 32'hFFFFFFF5, 3'b000);
    run_one("2.5 trunc",      32'h40200000, 0,  2'd0, 32'h00000002, 3'b001);
    run_one("2.5 rne",        32'h40200000, 0,  2'd1, 32'h00000002, 3'b001);
    run_one("2.5 floor",      32'h40200000, 0,  2'd2, 32'h00000002, 3'b001);
    run_one("2.5 ceil",       32'h40200000, 0,  2'd3, 32'h00000003, 3'b001);
    run_one("-2.5 floor",     32'hC0200000, 0,  2'd2, 32'hFFFFFFFD, 3'b001);
    run_one("3.5 rne",        32'h40600000, 0,  2'd1, 32'h00000004, 3'b001);
    run_one("0.5 rne",        32'h3F000000, 0,  2'd1, 32'h00000000, 3'b001);
    run_one("0.5 p31",        32'h3F000000, 31, 2'd0, 32'h40000000, 3'b000);
    run_one("1.0 p31 sat",    32'h3F800000, 31, 2'd0, 32'h7FFFFFFF, 3'b010);
    run_one("-1.0 p31 min",   32'hBF800000, 31, 2'd0, 32'h80000000, 3'b000);
    run_one("1e10 sat",       32'h501502F9, 0,  2'd0, 32'h7FFFFFFF, 3'b010);
    run_one("-2^31 exact",    32'hCF000000, 0,  2'd0, 32'h80000000, 3'b000);
    run_one("-inf",           32'hFF800000, 0,  2'd0, 32'h80000000, 3'b010);
    run_one("+inf",           32'h7F800000, 8,  2'd1, 32'h7FFFFFFF, 3'b010);
    run_one("nan",            32'h7FC00000, 0,  2'd0, 32'h00000000, 3'b100);
    run_one("-0",             32'h80000000, 3,  2'd2, 32'h00000000, 3'b000);
    run_one("-denorm floor",  32'h80000001, 0,  2'd2, 32'hFFFFFFFF, 3'b001);
    run_one("+denorm ceil",   32'h00400000, 0,  2'd3, 32'h00000001, 3'b001);
    run_one("+denorm trunc",  32'h00400000, 0,  2'd0, 32'h00000000, 3'b001);
    run_one("tiny ceil",      32'h00800000, 0,  2'd3, 32'h00000001, 3'b001);

    // Backpressure: six back-to-back inputs, output stalled for five cycles.
    sent = 0; got = 0; first_out = -1; last_out = -1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      float_in  = bp_vec[sent < 6 ? sent : 5];
      pos       = 5'd0;
      mode      = 2'd0;
      #1;
      if (cyc == 3) check("bp accepts before stall", 64'(sent), 64'd3);
      if (cyc == 3 || cyc == 4) begin
        check("bp in_ready low", 64'(in_ready), 64'd0);
        check("bp out_valid held", 64'(out_valid), 64'd1);
        check("bp result held", 64'(result), 64'd1);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("bp order", 64'(result), 64'(got + 1));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp all delivered", 64'(got), 64'd6);
    check("bp one per cycle", 64'(last_out - first_out), 64'd5);

    // Reset with two transactions in flight.
    @(negedge clk);
    in_valid = 1'b1; float_in = 32'h40E00000; pos = 5'd0; mode = 2'd0;
    @(negedge clk);
    float_in = 32'h41000000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    check("midrst no stale output", 64'(got), 64'd0);
    run_one("9.0 after reset", 32'h41100000, 0, 2'd0, 32'h00000009, 3'b000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
